// File: rtl/vrased_reset_seq.sv
// Reset sequencer for the VRASED monitors.
// Turns any violation request into a CPU reset that lasts at least HOLD_CYCLES
// cycles and is then held until the CPU fetches from the reset handler.
// It also records which monitors fired and how many sequences have started.
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   pc           current CPU program counter
//   viol         violation requests: [0] X_stack, [1] AC, [2] atomicity,
//                [3] dma_AC, [4] dma_detect, [5] dma_X_stack, [6] rata
//   cause_clr    clears the sticky cause register (honoured only when idle)
//   reset        registered system reset to the CPU
//   cause        sticky OR of every viol bit seen since the last clear
//   first_cause  lowest set viol index at the most recent sequence start
//   viol_cnt     number of sequence starts, saturating at 8'hFF
//   busy         high while a reset sequence is in progress
module vrased_reset_seq #(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [7:0]  HOLD_CYCLES   = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [6:0]  viol,
    input  logic        cause_clr,
    output logic        reset,
    output logic [6:0]  cause,
    output logic [2:0]  first_cause,
    output logic [7:0]  viol_cnt,
    output logic        busy
);

    localparam int unsigned VIOL_W = 7;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        WAIT_PC = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_cnt_next;
    logic [VIOL_W-1:0]  cause_next;
    logic [VIOL_W-1:0]  clr_mask;
    logic [IDX_W-1:0]   first_cause_next;
    logic [IDX_W-1:0]   lowest_idx;
    logic [CNT_W-1:0]   viol_cnt_next;
    logic               seq_next;
    logic               viol_any;

    assign viol_any = |viol;

    // Priority encoder: lowest set violation index wins.
    always_comb begin
        lowest_idx = '0;
        for (int i = VIOL_W - 1; i >= 0; i--) begin
            if (viol[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // Next-state, hold counter and bookkeeping.
    always_comb begin
        state_next       = state;
        hold_cnt_next    = hold_cnt;
        first_cause_next = first_cause;
        viol_cnt_next    = viol_cnt;
        clr_mask         = '0;

        case (state)
            IDLE: begin
                if (viol_any) begin
                    state_next       = HOLD;
                    hold_cnt_next    = HOLD_CYCLES - CNT_W'(1);
                    first_cause_next = lowest_idx;
                    if (viol_cnt != {CNT_W{1'b1}}) begin
                        viol_cnt_next = viol_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // A fresh violation restarts the minimum hold window.
                if (viol_any) begin
                    hold_cnt_next = HOLD_CYCLES - CNT_W'(1);
                end else if (hold_cnt == '0) begin
                    state_next = WAIT_PC;
                end else begin
                    hold_cnt_next = hold_cnt - CNT_W'(1);
                end
            end
            WAIT_PC: begin
                // Violation takes priority over reaching the reset handler.
                if (viol_any) begin
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_CYCLES - CNT_W'(1);
                end else if (pc == RESET_HANDLER) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase

        // Clear only while idle; a bit set in the same cycle survives.
        if (cause_clr && (state == IDLE)) begin
            clr_mask = {VIOL_W{1'b1}};
        end
        cause_next = (cause & ~clr_mask) | viol;

        seq_next = (state_next != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cause       <= '0;
            first_cause <= '0;
            viol_cnt    <= '0;
            reset       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            cause       <= cause_next;
            first_cause <= first_cause_next;
            viol_cnt    <= viol_cnt_next;
            reset       <= seq_next;
            busy        <= seq_next;
        end
    end

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for vrased_reset_seq with HOLD_CYCLES=4, RESET_HANDLER=0.
module tb_vrased_reset_seq;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [6:0]  viol;
    logic        cause_clr;
    logic        reset;
    logic [6:0]  cause;
    logic [2:0]  first_cause;
    logic [7:0]  viol_cnt;
    logic        busy;

    int n_assert;
    int n_fail;

    vrased_reset_seq #(
        .RESET_HANDLER (16'h0000),
        .HOLD_CYCLES   (8'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .viol        (viol),
        .cause_clr   (cause_clr),
        .reset       (reset),
        .cause       (cause),
        .first_cause (first_cause),
        .viol_cnt    (viol_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        pc        = 16'h0000;
        viol      = 7'h00;
        cause_clr = 1'b0;

        // Reset state
        step();
        chk("rst_reset",       32'(reset),       32'd0);
        chk("rst_cause",       32'(cause),       32'h0);
        chk("rst_first_cause", 32'(first_cause), 32'd0);
        chk("rst_viol_cnt",    32'(viol_cnt),    32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        rst = 1'b0;
        step();
        chk("idle_reset", 32'(reset), 32'd0);

        // Single-cycle atomicity pulse, pc already at the handler
        viol = 7'b0000100;
        step();
        viol = 7'h00;
        chk("s1_reset_n1",   32'(reset),       32'd1);
        chk("s1_busy",       32'(busy),        32'd1);
        chk("s1_cause",      32'(cause),       32'h04);
        chk("s1_first",      32'(first_cause), 32'd2);
        chk("s1_cnt",        32'(viol_cnt),    32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("s1_reset_hold", 32'(reset), 32'd1);
        end
        step();
        chk("s1_reset_end", 32'(reset), 32'd0);
        chk("s1_busy_end",  32'(busy),  32'd0);
        chk("s1_cause_end", 32'(cause), 32'h04);

        // Clear cause while idle, then park pc away from the handler
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        chk("s2_clr_cause", 32'(cause), 32'h0);
        pc   = 16'hE010;
        viol = 7'h01;
        step();
        viol = 7'h00;
        chk("s2_reset",  32'(reset),       32'd1);
        chk("s2_cnt",    32'(viol_cnt),    32'd2);
        chk("s2_first",  32'(first_cause), 32'd0);
        chk("s2_cause",  32'(cause),       32'h01);
        for (int i = 0; i < 24; i++) begin
            step();
            chk("s2_wait_reset", 32'(reset), 32'd1);
        end
        pc = 16'h0000;
        step();
        chk("s2_exit_reset", 32'(reset), 32'd0);
        chk("s2_exit_busy",  32'(busy),  32'd0);

        // Retrigger in HOLD at counter=1, then violation in WAIT_PC beats pc match
        rst_pulse();
        pc   = 16'h0000;
        viol = 7'h40;
        step();                         // E0: counter=3
        viol = 7'h00;
        chk("s3_first", 32'(first_cause), 32'd6);
        chk("s3_cnt",   32'(viol_cnt),    32'd1);
        step();                         // E1: counter=2
        step();                         // E2: counter=1
        viol = 7'h40;
        step();                         // E3: reload to 3
        viol = 7'h00;
        for (int i = 4; i <= 7; i++) begin
            step();                     // E4..E7, WAIT_PC after E7
            chk("s3_reset_reload", 32'(reset), 32'd1);
        end
        viol = 7'h01;
        step();                         // E8: back to HOLD
        viol = 7'h00;
        chk("s3_reset_pc_vs_viol", 32'(reset),       32'd1);
        chk("s3_cause",            32'(cause),       32'h41);
        chk("s3_cnt2",             32'(viol_cnt),    32'd1);
        chk("s3_first2",           32'(first_cause), 32'd6);
        for (int i = 9; i <= 12; i++) begin
            step();
            chk("s3_reset_hold2", 32'(reset), 32'd1);
        end
        step();                         // E13: IDLE
        chk("s3_reset_end", 32'(reset), 32'd0);

        // Clear and set in the same idle cycle; clear ignored while busy
        cause_clr = 1'b1;
        viol      = 7'h02;
        step();
        viol = 7'h00;
        chk("s4_cause_set_beats_clr", 32'(cause),       32'h02);
        chk("s4_reset",               32'(reset),       32'd1);
        chk("s4_cnt",                 32'(viol_cnt),    32'd2);
        chk("s4_first",               32'(first_cause), 32'd1);
        step();
        chk("s4_cause_busy_clr", 32'(cause), 32'h02);
        cause_clr = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("s4_busy_end",  32'(busy),  32'd0);
        chk("s4_cause_end", 32'(cause), 32'h02);
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        chk("s4_clr_cause",  32'(cause),       32'h0);
        chk("s4_clr_cnt",    32'(viol_cnt),    32'd2);
        chk("s4_clr_first",  32'(first_cause), 32'd1);

        // 256 sequences saturate viol_cnt
        rst_pulse();
        for (int i = 1; i <= 256; i++) begin
            viol = 7'h01;
            step();
            viol = 7'h00;
            chk("s5_viol_cnt", 32'(viol_cnt), (i < 255) ? 32'(i) : 32'd255);
            for (int k = 0; k < 5; k++) step();
        end
        chk("s5_idle", 32'(busy), 32'd0);

        // Asynchronous rst during WAIT_PC
        rst_pulse();
        viol = 7'h10;
        step();
        viol = 7'h00;
        pc   = 16'hE010;
        for (int i = 0; i < 6; i++) step();
        chk("s6_reset_wait", 32'(reset), 32'd1);
        chk("s6_cause",      32'(cause), 32'h10);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_reset", 32'(reset),    32'd0);
        chk("s6_async_cause", 32'(cause),    32'h0);
        chk("s6_async_cnt",   32'(viol_cnt), 32'd0);
        chk("s6_async_busy",  32'(busy),     32'd0);
        #1;
        rst  = 1'b0;
        viol = 7'h08;
        step();
        viol = 7'h00;
        chk("s6_post_rst_reset", 32'(reset),       32'd1);
        chk("s6_post_rst_first", 32'(first_cause), 32'd3);
        chk("s6_post_rst_cnt",   32'(viol_cnt),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
